// File: rtl/qspi_mem_responder.sv
// QSPI target that bridges quad-mode read (0xEB) and write (0x38) transfers onto a
// byte-wide synchronous memory port; all QSPI pins are oversampled on clk_i.
module qspi_mem_responder #(
  parameter int AW    = 10,
  parameter int DUMMY = 4
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          cs_in,
  input  logic          sck_i,
  input  logic [3:0]    sd_i,
  output logic [3:0]    sd_o,
  output logic [3:0]    sd_oen_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [7:0]    mem_rdata_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_SKIP  = 3'd6;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);

  logic          cs_s1_q, cs_s2_q, cs_d_q;
  logic          sck_s1_q, sck_s2_q, sck_d_q;
  logic [3:0]    sd_s1_q, sd_s2_q;
  logic [1:0]    warm_q, warm_d;
  logic          armed_q, armed_d;
  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          is_rd_q, is_rd_d;
  logic [19:0]   sh_q, sh_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [3:0]    whi_q, whi_d;
  logic [7:0]    pf_q, pf_d;
  logic          rvalid_q, rvalid_d;
  logic [3:0]    sd_o_q, sd_o_d;
  logic [3:0]    oen_q, oen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          re_q, re_d;

  logic          sck_rise, sck_fall, cs_fall;
  logic [23:0]   addr_full;
  logic [7:0]    cmd_byte;
  logic          unused_addr_hi;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_d_q   <= 1'b1;
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_d_q  <= 1'b0;
      sd_s1_q  <= 4'h0;
      sd_s2_q  <= 4'h0;
    end else begin
      cs_s1_q  <= cs_in;
      cs_s2_q  <= cs_s1_q;
      cs_d_q   <= cs_s2_q;
      sck_s1_q <= sck_i;
      sck_s2_q <= sck_s1_q;
      sck_d_q  <= sck_s2_q;
      sd_s1_q  <= sd_i;
      sd_s2_q  <= sd_s1_q;
    end
  end

  // A CS falling edge only counts once CS has been seen high with real (post-reset) samples.
  assign cs_fall   = armed_q & cs_d_q & ~cs_s2_q;
  assign sck_rise  = ~cs_s2_q & sck_s2_q & ~sck_d_q;
  assign sck_fall  = ~cs_s2_q & ~sck_s2_q & sck_d_q;
  assign addr_full = {sh_q, sd_s2_q};
  assign cmd_byte  = {sh_q[3:0], sd_s2_q};
  assign unused_addr_hi = ^addr_full;

  always_comb begin
    warm_d   = {warm_q[0], 1'b1};
    armed_d  = armed_q | (warm_q[1] & cs_s2_q);
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    is_rd_d  = is_rd_q;
    sh_d     = sck_rise ? {sh_q[15:0], sd_s2_q} : sh_q;
    ptr_d    = ptr_q;
    whi_d    = whi_q;
    rvalid_d = re_q;
    pf_d     = rvalid_q ? mem_rdata_i : pf_q;
    sd_o_d   = sd_o_q;
    oen_d    = oen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    if (cs_s2_q) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      phase_d = 1'b0;
      oen_d   = 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = 8'd0;
            phase_d = 1'b0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            if (cnt_q == 8'd1) begin
              cnt_d = 8'd0;
              if (cmd_byte == 8'hEB) begin
                state_d = S_ADDR;
                is_rd_d = 1'b1;
              end else if (cmd_byte == 8'h38) begin
                state_d = S_ADDR;
                is_rd_d = 1'b0;
              end else begin
                state_d = S_SKIP;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            if (cnt_q == 8'd5) begin
              cnt_d   = 8'd0;
              phase_d = 1'b0;
              ptr_d   = addr_full[AW-1:0];
              if (is_rd_q) begin
                re_d    = 1'b1;
                addr_d  = addr_full[AW-1:0];
                state_d = (DUMMY == 0) ? S_RD : S_DUMMY;
              end else begin
                state_d = S_WR;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 8'd0;
              state_d = S_RD;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_RD: begin
          // Driving the low nibble frees the prefetch slot, so fetch the next byte now.
          if (sck_fall) begin
            oen_d = 4'hF;
            if (!phase_q) begin
              sd_o_d  = pf_q[7:4];
              phase_d = 1'b1;
            end else begin
              sd_o_d  = pf_q[3:0];
              phase_d = 1'b0;
              ptr_d   = ptr_q + AW'(1);
              addr_d  = ptr_q + AW'(1);
              re_d    = 1'b1;
            end
          end
        end
        S_WR: begin
          if (sck_rise) begin
            if (!phase_q) begin
              whi_d   = sd_s2_q;
              phase_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = {whi_q, sd_s2_q};
              ptr_d   = ptr_q + AW'(1);
              phase_d = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      warm_q   <= 2'b00;
      armed_q  <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      phase_q  <= 1'b0;
      is_rd_q  <= 1'b0;
      sh_q     <= 20'h0;
      ptr_q    <= '0;
      whi_q    <= 4'h0;
      pf_q     <= 8'h0;
      rvalid_q <= 1'b0;
      sd_o_q   <= 4'h0;
      oen_q    <= 4'h0;
      addr_q   <= '0;
      wdata_q  <= 8'h0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      is_rd_q  <= is_rd_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      whi_q    <= whi_d;
      pf_q     <= pf_d;
      rvalid_q <= rvalid_d;
      sd_o_q   <= sd_o_d;
      oen_q    <= oen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
    end
  end

  assign sd_o        = sd_o_q;
  assign sd_oen_o    = oen_q & {4{~cs_s2_q}};
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign mem_re_o    = re_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Bench for qspi_mem_responder: directed vector table, hand-written reset sequences
// and random transfers scored against a byte-array model of the target memory.
module tb_qspi_mem_responder;
  localparam int AW = 10;
  localparam int DUMMY = 4;
  localparam int H = 5;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          sck = 1'b0;
  logic [3:0]    sd_in = 4'h0;
  logic [3:0]    sd_out, oen;
  logic [AW-1:0] maddr;
  logic [7:0]    mwdata, mrdata;
  logic          mwe, mre;
  logic          clr = 1'b1;

  qspi_mem_responder #(.AW(AW), .DUMMY(DUMMY)) dut (
    .clk_i(clk), .rst_in(rst_n), .cs_in(cs_n), .sck_i(sck), .sd_i(sd_in),
    .sd_o(sd_out), .sd_oen_o(oen), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_we_o(mwe), .mem_re_o(mre), .mem_rdata_i(mrdata)
  );

  // Backing memory the DUT talks to.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h0;
    end else begin
      if (mwe) mem[maddr] <= mwdata;
      if (mre) mrdata <= mem[maddr];
    end
  end

  logic [AW-1:0] wr_a[$];
  logic [7:0]    wr_d[$];
  int re_cnt = 0;
  int ovl = 0;
  always @(negedge clk) begin
    if (mwe) begin
      wr_a.push_back(maddr);
      wr_d.push_back(mwdata);
    end
    if (mre) re_cnt++;
    if (mwe && mre) ovl++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [3:0] tx_nib [16];
  logic [3:0] rx_nib [16];
  logic [3:0] rx_oe  [16];
  logic [3:0] pre_oe, post_oe;
  logic [7:0] ref_mem [DEPTH];

  task automatic sck_cycle(input logic [3:0] n, output logic [3:0] so, output logic [3:0] oe);
    sd_in = n;
    repeat (H) @(negedge clk);
    so = sd_out;
    oe = oen;
    sck = 1'b1;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] cmd, input logic [23:0] addr, input int nnib);
    logic [3:0] so, oe;
    pre_oe = 4'h0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    sck_cycle(cmd[7:4], so, oe); pre_oe |= oe;
    sck_cycle(cmd[3:0], so, oe); pre_oe |= oe;
    for (int i = 0; i < 6; i++) begin
      sck_cycle(addr[23-4*i -: 4], so, oe);
      pre_oe |= oe;
    end
    if (cmd == 8'hEB) begin
      for (int i = 0; i < DUMMY; i++) begin
        sck_cycle(4'h0, so, oe);
        pre_oe |= oe;
      end
    end
    for (int i = 0; i < nnib; i++) begin
      sck_cycle(tx_nib[i], so, oe);
      rx_nib[i] = so;
      rx_oe[i]  = oe;
    end
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    post_oe = oen;
  endtask

  // Expected behaviour straight from the protocol rules: whole bytes land at
  // consecutive wrapped addresses; reads return the model bytes nibble by nibble.
  task automatic model_check(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                             input int nnib, input int wr0, input int re0);
    int nwe, nre, base, idx, oe_any;
    logic [7:0] b, d;
    logic [3:0] e;
    nwe  = wr_a.size() - wr0;
    nre  = re_cnt - re0;
    base = int'(addr) % DEPTH;
    if (cmd == 8'h38) begin
      chk($sformatf("%s_nwe", tag), nwe, nnib / 2);
      for (int i = 0; i < nnib / 2; i++) begin
        idx = (base + i) % DEPTH;
        d = {tx_nib[2*i], tx_nib[2*i+1]};
        if (i < nwe) begin
          chk($sformatf("%s_wa%0d", tag, i), wr_a[wr0+i], idx);
          chk($sformatf("%s_wd%0d", tag, i), wr_d[wr0+i], d);
        end
        ref_mem[idx] = d;
      end
      chk($sformatf("%s_nre", tag), nre, 0);
    end else if (cmd == 8'hEB) begin
      for (int i = 0; i < nnib; i++) begin
        b = ref_mem[(base + i / 2) % DEPTH];
        e = (i % 2 == 0) ? b[7:4] : b[3:0];
        chk($sformatf("%s_rd%0d", tag, i), rx_nib[i], e);
        chk($sformatf("%s_oe%0d", tag, i), rx_oe[i], 4'hF);
      end
      chk($sformatf("%s_nwe", tag), nwe, 0);
      chk($sformatf("%s_nre", tag), nre, 1 + (nnib + 1) / 2);
    end else begin
      oe_any = 0;
      for (int i = 0; i < nnib; i++) if (rx_oe[i] != 4'h0) oe_any = 1;
      chk($sformatf("%s_skip_oe", tag), oe_any, 0);
      chk($sformatf("%s_nwe", tag), nwe, 0);
      chk($sformatf("%s_nre", tag), nre, 0);
    end
    chk($sformatf("%s_pre_oe", tag), pre_oe, 4'h0);
    chk($sformatf("%s_post_oe", tag), post_oe, 4'h0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nnib;
    logic [31:0] data;
    int          nwe;
    logic [9:0]  wa0;
    logic [7:0]  wd0;
    logic [9:0]  wa1;
    logic [7:0]  wd1;
    logic [15:0] rd;
    int          nre;
  } vec_t;

  vec_t vt [8];

  initial begin
    int wr0, re0, nnib, sel, act_n;
    logic [31:0] d32, a32;
    logic [23:0] addr;
    logic [7:0]  cmd;
    logic [15:0] act_rd;
    logic [3:0]  so, oe, oe_or;

    vt[0] = '{8'h38, 24'h000010, 4, 32'hA53C0000, 2, 10'h010, 8'hA5, 10'h011, 8'h3C, 16'h0000, 0};
    vt[1] = '{8'hEB, 24'h000010, 4, 32'h00000000, 0, 10'h000, 8'h00, 10'h000, 8'h00, 16'hA53C, 3};
    vt[2] = '{8'h38, 24'h0003FF, 4, 32'h11220000, 2, 10'h3FF, 8'h11, 10'h000, 8'h22, 16'h0000, 0};
    vt[3] = '{8'h9F, 24'h000000, 8, 32'h12345678, 0, 10'h000, 8'h00, 10'h000, 8'h00, 16'h0000, 0};
    vt[4] = '{8'h38, 24'h000000, 3, 32'h12300000, 1, 10'h000, 8'h12, 10'h000, 8'h00, 16'h0000, 0};
    vt[5] = '{8'hEB, 24'h000000, 2, 32'h00000000, 0, 10'h000, 8'h00, 10'h000, 8'h00, 16'h1200, 2};
    vt[6] = '{8'hEB, 24'hFFF010, 4, 32'h00000000, 0, 10'h000, 8'h00, 10'h000, 8'h00, 16'hA53C, 3};
    vt[7] = '{8'hEB, 24'h0003FF, 4, 32'h00000000, 0, 10'h000, 8'h00, 10'h000, 8'h00, 16'h1112, 3};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_oen", oen, 4'h0);
    chk("rst_sd_o", sd_out, 4'h0);
    chk("rst_addr", maddr, 0);
    chk("rst_wdata", mwdata, 8'h0);
    chk("rst_we", mwe, 1'b0);
    chk("rst_re", mre, 1'b0);
    clr = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      d32 = vt[v].data;
      for (int i = 0; i < 8; i++) tx_nib[i] = d32[31-4*i -: 4];
      wr0 = wr_a.size();
      re0 = re_cnt;
      run_xfer(vt[v].cmd, vt[v].addr, vt[v].nnib);
      chk($sformatf("v%0d_nwe", v), wr_a.size() - wr0, vt[v].nwe);
      chk($sformatf("v%0d_nre", v), re_cnt - re0, vt[v].nre);
      if (vt[v].nwe >= 1 && wr_a.size() > wr0) begin
        chk($sformatf("v%0d_wa0", v), wr_a[wr0], vt[v].wa0);
        chk($sformatf("v%0d_wd0", v), wr_d[wr0], vt[v].wd0);
      end
      if (vt[v].nwe >= 2 && wr_a.size() > wr0 + 1) begin
        chk($sformatf("v%0d_wa1", v), wr_a[wr0+1], vt[v].wa1);
        chk($sformatf("v%0d_wd1", v), wr_d[wr0+1], vt[v].wd1);
      end
      if (vt[v].cmd == 8'hEB) begin
        act_rd = 16'h0;
        for (int i = 0; i < vt[v].nnib && i < 4; i++) act_rd[15-4*i -: 4] = rx_nib[i];
        chk($sformatf("v%0d_rd", v), act_rd, vt[v].rd);
      end
      model_check($sformatf("v%0d", v), vt[v].cmd, vt[v].addr, vt[v].nnib, wr0, re0);
    end

    // Random transfers against the model
    for (int r = 0; r < 24; r++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) cmd = 8'hEB;
      else if (sel == 1) cmd = 8'h38;
      else begin
        cmd = 8'($urandom_range(0, 255));
        while (cmd == 8'hEB || cmd == 8'h38) cmd = 8'($urandom_range(0, 255));
      end
      a32 = $urandom;
      addr = {a32[23:10], 10'($urandom_range(0, 63))};
      if (r % 5 == 4) addr[9:0] = 10'($urandom_range(1018, 1023));
      nnib = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) tx_nib[i] = 4'($urandom_range(0, 15));
      wr0 = wr_a.size();
      re0 = re_cnt;
      run_xfer(cmd, addr, nnib);
      model_check($sformatf("r%0d", r), cmd, addr, nnib, wr0, re0);
    end

    // CS already low when reset is released: the transfer must be ignored
    rst_n = 1'b0;
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr0 = wr_a.size();
    re0 = re_cnt;
    oe_or = 4'h0;
    sck_cycle(4'h3, so, oe); oe_or |= oe;
    sck_cycle(4'h8, so, oe); oe_or |= oe;
    for (int i = 0; i < 10; i++) begin
      sck_cycle(4'(i), so, oe);
      oe_or |= oe;
    end
    chk("csrel_nwe", wr_a.size() - wr0, 0);
    chk("csrel_nre", re_cnt - re0, 0);
    chk("csrel_oe", oe_or, 4'h0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    tx_nib[0] = 4'h7; tx_nib[1] = 4'h7;
    wr0 = wr_a.size();
    re0 = re_cnt;
    run_xfer(8'h38, 24'h000020, 2);
    model_check("csrel_after", 8'h38, 24'h000020, 2, wr0, re0);

    // Reset asserted in the middle of a read
    tx_nib[0] = 4'hA; tx_nib[1] = 4'h5;
    wr0 = wr_a.size();
    re0 = re_cnt;
    run_xfer(8'h38, 24'h000010, 2);
    model_check("rdrst_prep", 8'h38, 24'h000010, 2, wr0, re0);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    sck_cycle(4'hE, so, oe);
    sck_cycle(4'hB, so, oe);
    for (int i = 0; i < 6; i++) sck_cycle((i == 4) ? 4'h1 : 4'h0, so, oe);
    for (int i = 0; i < DUMMY; i++) sck_cycle(4'h0, so, oe);
    sck_cycle(4'h0, so, oe);
    chk("rdrst_first_nib", so, 4'hA);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rdrst_oen", oen, 4'h0);
    chk("rdrst_sd_o", sd_out, 4'h0);
    chk("rdrst_addr", maddr, 0);
    chk("rdrst_we", mwe, 1'b0);
    chk("rdrst_re", mre, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wr0 = wr_a.size();
    re0 = re_cnt;
    oe_or = 4'h0;
    for (int i = 0; i < 6; i++) begin
      sck_cycle(4'h5, so, oe);
      oe_or |= oe;
    end
    chk("rdrst_nwe", wr_a.size() - wr0, 0);
    chk("rdrst_nre", re_cnt - re0, 0);
    chk("rdrst_oe", oe_or, 4'h0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    wr0 = wr_a.size();
    re0 = re_cnt;
    run_xfer(8'hEB, 24'h000010, 4);
    model_check("rdrst_after", 8'hEB, 24'h000010, 4, wr0, re0);

    chk("we_re_exclusive", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
